// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter driving a shared 4:1 mux with a registered valid/ready output stage.
// Optional per-requester saturating grant counters are enabled by defining RR_MUX_ARB_GRANT_CNT_EN.
module rr_mux_arbiter_4 #(
   parameter int W = 4,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   in_valid,
   input  logic [W-1:0]   d0,
   input  logic [W-1:0]   d1,
   input  logic [W-1:0]   d2,
   input  logic [W-1:0]   d3,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [1:0]     out_sel,
   input  logic           out_ready
`ifdef RR_MUX_ARB_GRANT_CNT_EN
   ,
   output logic [8*N-1:0] grant_cnt
`endif
);

   logic [1:0]   last;
   logic         load;
   logic         any_grant;
   logic [1:0]   gnt_idx;
   logic [N-1:0] grant;
   logic [W-1:0] gnt_data;

   assign load = ~out_valid | out_ready;

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      logic [1:0] idx;
      any_grant = 1'b0;
      gnt_idx   = last;
      grant     = '0;
      idx       = last;
      for (int k = 1; k <= 4; k++) begin
         idx = last + k[1:0];
         if (!any_grant && in_valid[idx]) begin
            any_grant    = 1'b1;
            gnt_idx      = idx;
            grant[idx]   = 1'b1;
         end
      end
   end

   always_comb begin
      gnt_data = d0;
      case (gnt_idx)
         2'd0:    gnt_data = d0;
         2'd1:    gnt_data = d1;
         2'd2:    gnt_data = d2;
         default: gnt_data = d3;
      endcase
   end

   assign in_ready = (load && !rst) ? grant : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= 2'd0;
         last      <= 2'd3;
      end else if (load) begin
         if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt_idx;
            last      <= gnt_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef RR_MUX_ARB_GRANT_CNT_EN
   logic [7:0] cnt [N];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) cnt[i] <= 8'd0;
      end else if (load && any_grant) begin
         for (int i = 0; i < N; i++) begin
            if (gnt_idx == 2'(i) && cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) grant_cnt[8*i +: 8] = cnt[i];
   end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Bench for rr_mux_arbiter_4: vector table with an output scoreboard, plus reset sequences.
module tb_rr_mux_arbiter_4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid;
   logic [3:0]  d0, d1, d2, d3;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_ready;
`ifdef RR_MUX_ARB_GRANT_CNT_EN
   logic [31:0] grant_cnt;
`endif

   rr_mux_arbiter_4 #(.W(4), .N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
`ifdef RR_MUX_ARB_GRANT_CNT_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  iv;
      logic [15:0] data;
      logic        ordy;
      logic [3:0]  exp;
   } vec_t;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] data;
   } sb_t;

   vec_t vt[$];
   sb_t  sb[$];

   int   n_checks = 0;
   int   n_fail   = 0;

   logic       m_valid;
   logic [1:0] m_sel;
   logic [3:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] oh_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   function automatic void add(input logic [3:0] iv, input logic [15:0] data,
                               input logic ordy, input logic [3:0] exp);
      vec_t v;
      v.iv = iv; v.data = data; v.ordy = ordy; v.exp = exp;
      vt.push_back(v);
   endfunction

   task automatic step(input vec_t v);
      logic       exp_load;
      logic [1:0] g;
      sb_t        e;
      @(negedge clk);
      in_valid  = v.iv;
      {d3, d2, d1, d0} = v.data;
      out_ready = v.ordy;
      #1;
      chk("in_ready", 32'(in_ready), 32'(v.exp));
      exp_load = !m_valid || v.ordy;
      if (v.exp != 4'b0000) begin
         g      = oh_idx(v.exp);
         e.sel  = g;
         e.data = v.data[int'(g)*4 +: 4];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (v.exp != 4'b0000) begin
         e       = sb.pop_front();
         m_sel   = e.sel;
         m_data  = e.data;
         m_valid = 1'b1;
      end else if (exp_load) begin
         m_valid = 1'b0;
      end
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_sel",   32'(out_sel),   32'(m_sel));
      chk("out_data",  32'(out_data),  32'(m_data));
   endtask

   // Two reset cycles: the first clears the registers, the second checks in_ready gating while load is high.
   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 4'b1111;
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sel",   32'(out_sel),   32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_out_valid2", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 4'b0000;
      sb.delete();
      m_valid = 1'b0;
      m_sel   = 2'd0;
      m_data  = 4'd0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
      {d3, d2, d1, d0} = 16'h0000;
      m_valid = 1'b0; m_sel = 2'd0; m_data = 4'd0;

      // Idle after reset
      for (int i = 0; i < 5; i++) add(4'b0000, 16'h0000, 1'b1, 4'b0000);
      // All requesters valid: strict rotation
      for (int i = 0; i < 8; i++) add(4'b1111, 16'hDCBA, 1'b1, 4'b0001 << (i % 4));
      // Grant 1, stall for four cycles, then rotation resumes at 2
      add(4'b0010, 16'h0050, 1'b1, 4'b0010);
      for (int i = 0; i < 4; i++) add(4'b1111, 16'h0050, 1'b0, 4'b0000);
      add(4'b1111, 16'h4321, 1'b1, 4'b0100);
      // Lone requester 3, then wrap to 0
      for (int i = 0; i < 3; i++) add(4'b1000, 16'h7000, 1'b1, 4'b1000);
      add(4'b1001, 16'h7009, 1'b1, 4'b0001);
      add(4'b1000, 16'h7000, 1'b1, 4'b1000);
      // Idle cycles must not rotate priority
      add(4'b0000, 16'h0000, 1'b1, 4'b0000);
      add(4'b0000, 16'h0000, 1'b0, 4'b0000);
      // d3 is X and never selected
      add(4'b0111, 16'hx3A7, 1'b1, 4'b0001);
      add(4'b0111, 16'hx3A7, 1'b1, 4'b0010);
      add(4'b0111, 16'hx3A7, 1'b1, 4'b0100);
      add(4'b0000, 16'hx3A7, 1'b1, 4'b0000);
      // Load a word and stall it before the mid-run reset
      add(4'b0100, 16'h0800, 1'b1, 4'b0100);
      add(4'b0000, 16'h0000, 1'b0, 4'b0000);

      do_reset();
      foreach (vt[i]) begin
         step(vt[i]);
         if (vt[i].data === 16'hx3A7 && vt[i].exp != 4'b0000)
            chk("no_x_out_data", 32'($isunknown(out_data)), 32'd0);
      end

      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      do_reset();
      begin
         vec_t v;
         v.iv = 4'b1111; v.data = 16'h4321; v.ordy = 1'b1; v.exp = 4'b0001;
         step(v);
`ifdef RR_MUX_ARB_GRANT_CNT_EN
         v.iv = 4'b0001; v.data = 16'h0009; v.ordy = 1'b1; v.exp = 4'b0001;
         for (int i = 0; i < 300; i++) step(v);
         chk("grant_cnt0_sat", 32'(grant_cnt[7:0]), 32'd255);
         chk("grant_cnt_others", 32'(grant_cnt[31:8]), 32'd0);
`endif
      end
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Round-robin arbiter and sequencer for a shared 4-to-1, 4-bit multiplexer datapath.
- Up to four requesters each present a 4-bit word with valid/ready.
- The block picks one requester per cycle, drives the mux select, and registers the selected word onto a single valid/ready output.
- It sits between independent producers and one shared consumer, and is the only driver of the mux select.

Parameters:
- W, 4, data width of each requester word and of the output word.
- N, 4, number of requesters; fixed at 4; select width is 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- d0, d1, d2, d3  input  W each  requester data words.
- in_ready  output  4  per-requester accept strobe; one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered selected word.
- out_sel  output  2  index of the requester whose word is in out_data.
- out_ready  input  1  consumer accepts out_data when high together with out_valid.

Behaviour:
- Reset, synchronous and active-high, applied at any time:
  - out_valid=0, out_data=0, out_sel=0.
  - last-grant pointer=3, so requester 0 has top priority first.
  - Any word in the output register is discarded.
  - in_ready is 0 during the reset cycle.
- Load enable: load = ~out_valid | out_ready. It is combinational and uses no extra buffer.
- Grant search:
  - Scan indices last+1, last+2, last+3, last+4, all mod 4.
  - The first index with in_valid=1 wins.
  - No in_valid bits set means no grant.
- in_ready[i] = load & grant[i]. It is combinational from in_valid, out_valid, out_ready and pointer state.
  - At most one bit is high.
  - It is zero whenever load=0.
- On a clock edge with load=1 and a grant g:
  - out_data <= d[g], out_sel <= g, out_valid <= 1, last <= g.
  - Requester g's word counts as transferred on that edge.
- On a clock edge with load=1 and no grant: out_valid <= 0. out_data and out_sel hold their old values, which are don't-care.
- On a clock edge with load=0 (out_valid=1, out_ready=0): all outputs and the pointer hold. No requester is accepted.
- Latency: one cycle from accept edge to out_valid.
- Throughput: one word per cycle while out_ready=1.
- Fairness:
  - With all 4 requesters valid, grants go 0,1,2,3,0,...
  - A requester waits at most 3 grants after it raises valid, given that the consumer keeps draining.
- Pointer updates only on an actual grant. Idle cycles do not rotate priority.
- Wrap-around: last=3 makes index 0 the first in the search.
- Lone requester: if only one requester is valid, it is granted every loadable cycle.
- Requester protocol: a requester may drop in_valid before it is granted. No data is lost and the block does not require valid to be held.
- d[i] is sampled only on its own grant edge. Unselected data, including X, never reaches out_data.

Optional Feature:
- Macro: RR_MUX_ARB_GRANT_CNT_EN.
- When defined:
  - Adds output grant_cnt, 4x8 bits, packed as grant_cnt[8*i+7:8*i] for requester i.
  - Each counter increments on every grant edge for its requester and saturates at 255.
  - All counters clear on rst.
- When undefined: no grant_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
1. Reset, then hold in_valid=4'b0000 for 5 cycles → out_valid=0, in_ready=0, out_sel=0 throughout.
2. in_valid=4'b1111, d0..d3=a,b,c,d, out_ready=1 for 8 cycles:
   - in_ready sequence 0001,0010,0100,1000, repeated.
   - One cycle later: out_sel 0,1,2,3,0,1,2,3 and out_data a,b,c,d,a,b,c,d.
3. Backpressure:
   - Grant requester 1 with d1=5, then hold out_ready=0 for 4 cycles → out_valid=1, out_data=5, out_sel=1 stable, in_ready=0.
   - Release out_ready with in_valid=4'b1111 → next grant is requester 2.
4. Only in_valid[3]=1, d3=7, out_ready=1 → in_ready=1000 every cycle, out_data=7, out_sel=3 each cycle. Then add in_valid[0] → next grant is 0, because of wrap after last=3.
5. Unselected X: d3=X, in_valid=4'b0111, d0=7, d1=A, d2=3 → outputs 7, A, 3 in order with no X on out_data.
6. Assert rst with out_valid=1 and out_ready=0 → next cycle out_valid=0. After release, the first grant goes to requester 0. With the macro defined, also check: after 300 grants to requester 0, grant_cnt[7:0]=255.
